// File: rtl/ps2_mouse_decode_funcmod.sv
// ps2_mouse_decode_funcmod
//   Takes 3-byte PS/2 mouse packets from the byte reader, validates them,
//   decodes buttons and signed X/Y deltas, and keeps an absolute cursor
//   position that is clamped to 0..XMAX / 0..YMAX. Screen Y grows downward.
//
//   Packet layout: iData[7:0]=status, [15:8]=X delta, [23:16]=Y delta.
//   Status bits  : 0=L 1=R 2=M 3=always 1 4=Xsign 5=Ysign 6=Xovf 7=Yovf.
//
// Ports
//   CLOCK    system clock
//   RESET    asynchronous reset, active low
//   iTrig    one-cycle packet-ready pulse (only taken in IDLE)
//   iData    24-bit packet, sampled when iTrig=1
//   iClear   recentre cursor and abort any packet in flight
//   oX/oY    cursor position
//   oBtn     {M,R,L} from the last accepted packet
//   oValid   one-cycle pulse: oX/oY/oBtn were updated
//   oErr     one-cycle pulse: packet rejected
//   oErrCnt  rejected-packet count, saturating at 255
//
// Build option
//   PS2M_OVF_DROP_EN : when defined, a packet with either overflow bit set is
//                      rejected. When undefined, an overflowed delta is
//                      replaced by +255 / -256 and the packet is used.
module ps2_mouse_decode_funcmod #(
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int XMAX  = 639,
    parameter int YMAX  = 479,
    parameter int XINIT = 320,
    parameter int YINIT = 240
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          iTrig,
    input  logic [23:0]   iData,
    input  logic          iClear,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic [2:0]    oBtn,
    output logic          oValid,
    output logic          oErr,
    output logic [7:0]    oErrCnt
);

    // Sum width: room for the largest position plus a 9-bit delta and a sign.
    localparam int SW = ((XW > YW) ? XW : YW) + 2;

    localparam logic signed [SW-1:0] XMAX_S = SW'(XMAX);
    localparam logic signed [SW-1:0] YMAX_S = SW'(YMAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_CLAMP,
        S_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [23:0]           pkt_q, pkt_d;
    logic signed [8:0]     dx_q, dx_d, dy_q, dy_d;
    logic signed [SW-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [2:0]            btn_q, btn_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic                  bad;
    logic signed [8:0]     dx_raw, dy_raw;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            pkt_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            x_q     <= XW'(XINIT);
            y_q     <= YW'(YINIT);
            btn_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            btn_q   <= btn_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Packet validation and delta formation, looked at in CHECK.
    always_comb begin
        dx_raw = {pkt_q[4], pkt_q[15:8]};
        dy_raw = {pkt_q[5], pkt_q[23:16]};
`ifdef PS2M_OVF_DROP_EN
        bad = ~pkt_q[3] | pkt_q[6] | pkt_q[7];
`else
        bad = ~pkt_q[3];
        // Overflowed axis: saturate to the extreme 9-bit value of its sign.
        if (pkt_q[6]) dx_raw = pkt_q[4] ? 9'sh100 : 9'sh0FF;
        if (pkt_q[7]) dy_raw = pkt_q[5] ? 9'sh100 : 9'sh0FF;
`endif
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        x_d     = x_q;
        y_d     = y_q;
        btn_d   = btn_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (iClear) begin
            // Recentre and drop whatever is in flight; buttons and count stay.
            state_d = S_IDLE;
            x_d     = XW'(XINIT);
            y_d     = YW'(YINIT);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iTrig) begin
                        pkt_d   = iData;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad) begin
                        err_d   = 1'b1;
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                        state_d = S_IDLE;
                    end else begin
                        dx_d    = dx_raw;
                        dy_d    = dy_raw;
                        state_d = S_ADD;
                    end
                end
                S_ADD: begin
                    // PS/2 +Y is up, screen +Y is down.
                    sx_d    = $signed(SW'(x_q)) + SW'(dx_q);
                    sy_d    = $signed(SW'(y_q)) - SW'(dy_q);
                    state_d = S_CLAMP;
                end
                S_CLAMP: begin
                    if (sx_q[SW-1])         x_d = '0;
                    else if (sx_q > XMAX_S) x_d = XW'(XMAX);
                    else                    x_d = sx_q[XW-1:0];
                    if (sy_q[SW-1])         y_d = '0;
                    else if (sy_q > YMAX_S) y_d = YW'(YMAX);
                    else                    y_d = sy_q[YW-1:0];
                    btn_d   = pkt_q[2:0];
                    state_d = S_OUT;
                end
                S_OUT: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Position registers load on the CLAMP->OUT edge, so oValid (the OUT
    // cycle) is exactly the cycle in which the outputs change.
    assign oX      = x_q;
    assign oY      = y_q;
    assign oBtn    = btn_q;
    assign oValid  = (state_q == S_OUT);
    assign oErr    = err_q;
    assign oErrCnt = cnt_q;

endmodule

// File: tb/tb_ps2_mouse_decode_funcmod.sv
module tb_ps2_mouse_decode_funcmod;

    localparam int XMAX = 639;
    localparam int YMAX = 479;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        iTrig = 1'b0;
    logic [23:0] iData = '0;
    logic        iClear = 1'b0;
    logic [9:0]  oX;
    logic [9:0]  oY;
    logic [2:0]  oBtn;
    logic        oValid;
    logic        oErr;
    logic [7:0]  oErrCnt;

    ps2_mouse_decode_funcmod dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iTrig  (iTrig),
        .iData  (iData),
        .iClear (iClear),
        .oX     (oX),
        .oY     (oY),
        .oBtn   (oBtn),
        .oValid (oValid),
        .oErr   (oErr),
        .oErrCnt(oErrCnt)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_err;
        int at;
        int x;
        int y;
        int btn;
        int cnt;
    } exp_t;

    exp_t sb[$];

    // Reference state: the cursor as the user would see it.
    int mx = 320, my = 240, mbtn = 0, mcnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Predict the outcome of one packet and queue it.
    task automatic predict(input logic [23:0] d);
        exp_t e;
        int   dx, dy;
        bit   bad;
        dx  = d[4] ? int'(d[15:8]) - 256 : int'(d[15:8]);
        dy  = d[5] ? int'(d[23:16]) - 256 : int'(d[23:16]);
        bad = !d[3];
`ifdef PS2M_OVF_DROP_EN
        if (d[6] || d[7]) bad = 1;
`else
        if (d[6]) dx = d[4] ? -256 : 255;
        if (d[7]) dy = d[5] ? -256 : 255;
`endif
        if (bad) begin
            if (mcnt < 255) mcnt++;
            e.is_err = 1;
            e.at     = cyc + 2;
        end else begin
            mx   = clampi(mx + dx, XMAX);
            my   = clampi(my - dy, YMAX);
            mbtn = int'(d[2:0]);
            e.is_err = 0;
            e.at     = cyc + 4;
        end
        e.x = mx; e.y = my; e.btn = mbtn; e.cnt = mcnt;
        sb.push_back(e);
    endtask

    // Issue one packet and let it drain before returning.
    task automatic send(input logic [23:0] d, input int gap);
        @(posedge CLOCK); #1;
        iTrig = 1'b1;
        iData = d;
        predict(d);
        @(posedge CLOCK); #1;
        iTrig = 1'b0;
        repeat (4 + gap) @(posedge CLOCK);
    endtask

    task automatic do_clear();
        @(posedge CLOCK); #1;
        iClear = 1'b1;
        @(posedge CLOCK); #1;
        iClear = 1'b0;
        mx = 320; my = 240;
        chk("clear_x", int'(oX), 320);
        chk("clear_y", int'(oY), 240);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK);
            if (RESET && (oValid || oErr)) begin
                if (oValid && oErr) chk("valid_and_err", 1, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", int'({oValid, oErr}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("kind_err", int'(oErr), int'(e.is_err));
                    chk("latency", cyc, e.at);
                    chk("x", int'(oX), e.x);
                    chk("y", int'(oY), e.y);
                    chk("btn", int'(oBtn), e.btn);
                    chk("errcnt", int'(oErrCnt), e.cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d;
        int          r;

        #12;
        chk("rst_x", int'(oX), 320);
        chk("rst_y", int'(oY), 240);
        chk("rst_btn", int'(oBtn), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_err", int'(oErr), 0);
        chk("rst_cnt", int'(oErrCnt), 0);
        RESET = 1'b1;
        repeat (2) @(posedge CLOCK);

        // Basic decode, negative X, button-only packet.
        send(24'h051009, 1);
        do_clear();
        send(24'h00F018, 1);
        send(24'h000008, 1);
        do_clear();

        // Clamp at XMAX then walk down to exactly 0.
        send(24'h007F08, 0);
        send(24'h007F08, 0);
        send(24'h003808, 0);
        chk("x_at_630", int'(oX), 630);
        send(24'h001408, 0);
        chk("x_clamp_max", int'(oX), 639);
        for (int i = 0; i < 22; i++) send(24'h00E018, 0);
        chk("x_clamp_zero", int'(oX), 0);

        // Sync loss, then saturation of the error count.
        send(24'h050900, 1);
        for (int i = 0; i < 256; i++) send(24'h000000, 0);
        chk("cnt_sat", int'(oErrCnt), 255);

        // Overflow packet from centre.
        do_clear();
        send(24'h007F48, 1);

        // Abort with iClear two cycles after the trigger: nothing is queued.
        @(posedge CLOCK); #1;
        iTrig = 1'b1; iData = 24'h051009;
        @(posedge CLOCK); #1;
        iTrig = 1'b0;
        @(posedge CLOCK); #1;
        iClear = 1'b1;
        @(posedge CLOCK); #1;
        iClear = 1'b0;
        mx = 320; my = 240;
        repeat (6) @(posedge CLOCK);
        chk("abort_x", int'(oX), 320);
        chk("abort_y", int'(oY), 240);

        // iClear and iTrig together: packet dropped.
        @(posedge CLOCK); #1;
        iTrig = 1'b1; iClear = 1'b1; iData = 24'h051009;
        @(posedge CLOCK); #1;
        iTrig = 1'b0; iClear = 1'b0;
        repeat (6) @(posedge CLOCK);

        // A trigger arriving during CLAMP is ignored.
        @(posedge CLOCK); #1;
        iTrig = 1'b1; iData = 24'h031019;
        predict(24'h031019);
        @(posedge CLOCK); #1;
        iTrig = 1'b0;
        @(posedge CLOCK); #1;
        @(posedge CLOCK); #1;
        iTrig = 1'b1; iData = 24'h000000;
        @(posedge CLOCK); #1;
        iTrig = 1'b0;
        repeat (6) @(posedge CLOCK);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                do_clear();
            end else begin
                d = 24'($urandom());
                d[3] = (r >= 3);
                send(d, int'($urandom_range(0, 3)));
            end
        end

        // Reset mid-packet: everything returns to reset values at once.
        @(posedge CLOCK); #1;
        iTrig = 1'b1; iData = 24'h051009;
        @(posedge CLOCK); #1;
        iTrig = 1'b0;
        @(posedge CLOCK); #3;
        RESET = 1'b0;
        #1;
        chk("arst_x", int'(oX), 320);
        chk("arst_y", int'(oY), 240);
        chk("arst_btn", int'(oBtn), 0);
        chk("arst_valid", int'(oValid), 0);
        chk("arst_cnt", int'(oErrCnt), 0);
        mx = 320; my = 240; mbtn = 0; mcnt = 0;
        @(negedge CLOCK);
        RESET = 1'b1;
        send(24'h051009, 2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CLOCK);
        chk("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
